// File: rtl/coletor_tx.sv
// -----------------------------------------------------------------------------
// coletor_tx
//
// Return-path collector. Up to N_SENSORS sensing modules raise a level request
// together with a 3-bit response code and an 8-bit data field. A round-robin
// arbiter picks one pending module, its code/data are latched, the module is
// acknowledged, and the response is serialized on a byte-wide UART
// transmitter as:
//   byte0 = {code[2:0], module_address[4:0]}
//   byte1 = data
//   byte2 = byte0 ^ byte1        (only when COLETOR_CHECKSUM_EN is defined)
//
// Optional feature macro: COLETOR_CHECKSUM_EN (adds the XOR checksum byte).
//
// Parameters:
//   N_SENSORS : number of request lines, 1..32 (address field is 5 bits).
//   DATA_W    : per-module data width; only 8 is supported (UART byte).
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   req            in   [N_SENSORS]   per-module level request, held until ack
//   resp_code_bus  in   [3*N]        module i code at [3i+2:3i]
//   resp_data_bus  in   [DATA_W*N]   module i data at [8i+7:8i]
//   ack            out  [N_SENSORS]  one-hot, one-cycle pulse in CAPTURE
//   tx_data        out  [8]          byte presented to the UART TX
//   tx_start       out               one-cycle pulse, tx_data valid with it
//   tx_busy        in                UART TX is shifting a byte
//   tx_done        in                one-cycle pulse, UART finished a byte
//   busy           out               high from capture to the final tx_done
// -----------------------------------------------------------------------------
module coletor_tx #(
  parameter int N_SENSORS = 32,
  parameter int DATA_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_SENSORS-1:0]          req,
  input  logic [3*N_SENSORS-1:0]        resp_code_bus,
  input  logic [DATA_W*N_SENSORS-1:0]   resp_data_bus,
  output logic [N_SENSORS-1:0]          ack,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic                          busy
);

  localparam int ADDR_W      = 5;
  localparam int MAX_SENSORS = 32;
  localparam int PROBE_W     = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SEND0,
    WAIT0,
    SEND1,
    WAIT1
`ifdef COLETOR_CHECKSUM_EN
    ,
    SEND2,
    WAIT2
`endif
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   rr_ptr;
  logic [ADDR_W-1:0]   win_idx;
  logic [2:0]          code_q;
  logic [DATA_W-1:0]   data_q;

  // Frame byte builders. Keeping them as functions makes the frame layout
  // readable in one place and shared by the checksum byte.
  function automatic logic [7:0] frame_hdr(input logic [2:0]        code,
                                           input logic [ADDR_W-1:0] addr);
    return {code, addr};
  endfunction

  function automatic logic [7:0] frame_data(input logic [DATA_W-1:0] data);
    return 8'(data);
  endfunction

`ifdef COLETOR_CHECKSUM_EN
  function automatic logic [7:0] frame_csum(input logic [2:0]        code,
                                            input logic [ADDR_W-1:0] addr,
                                            input logic [DATA_W-1:0] data);
    return frame_hdr(code, addr) ^ frame_data(data);
  endfunction
`endif

  // Requests and response fields are widened to the full 32-entry address
  // space so the arbiter and the capture mux can be indexed directly by a
  // 5-bit address; unimplemented entries read as zero.
  logic [MAX_SENSORS-1:0] req_pad;
  logic [2:0]             code_arr [MAX_SENSORS];
  logic [DATA_W-1:0]      data_arr [MAX_SENSORS];

  always_comb begin
    req_pad                 = '0;
    req_pad[N_SENSORS-1:0]  = req;
  end

  always_comb begin
    for (int i = 0; i < MAX_SENSORS; i++) begin
      code_arr[i] = '0;
      data_arr[i] = '0;
    end
    for (int i = 0; i < N_SENSORS; i++) begin
      code_arr[i] = resp_code_bus[3*i +: 3];
      data_arr[i] = resp_data_bus[DATA_W*i +: DATA_W];
    end
  end

  // Round-robin pick: first set request at or after rr_ptr, wrapping at
  // N_SENSORS-1 back to 0. rr_ptr always points one past the last winner,
  // so the module just served is examined last.
  logic                   pick_found;
  logic [ADDR_W-1:0]      pick_idx;
  logic [PROBE_W-1:0]     probe;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    probe      = '0;
    for (int k = 0; k < N_SENSORS; k++) begin
      probe = {1'b0, rr_ptr} + PROBE_W'(k);
      if (probe >= PROBE_W'(N_SENSORS)) begin
        probe = probe - PROBE_W'(N_SENSORS);
      end
      if (!pick_found && req_pad[probe[ADDR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = probe[ADDR_W-1:0];
      end
    end
  end

  logic [MAX_SENSORS-1:0] pick_onehot;
  logic [ADDR_W-1:0]      ptr_after_win;

  assign pick_onehot   = 32'd1 << pick_idx;
  assign ptr_after_win = (win_idx == ADDR_W'(N_SENSORS - 1)) ? '0
                                                             : win_idx + 5'd1;

  // Control FSM. ack and tx_start default low every cycle so each is a
  // single-cycle pulse; tx_data holds the last byte presented until the next
  // SEND state overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      win_idx  <= '0;
      code_q   <= '0;
      data_q   <= '0;
      ack      <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;

      case (state)
        // Arbitrate among pending levels; ack and busy are raised so they are
        // visible during the CAPTURE cycle.
        IDLE: begin
          if (pick_found) begin
            win_idx <= pick_idx;
            ack     <= pick_onehot[N_SENSORS-1:0];
            busy    <= 1'b1;
            state   <= CAPTURE;
          end
        end

        // The winner keeps its fields stable until it sees ack, so they are
        // latched at the end of the ack cycle.
        CAPTURE: begin
          code_q <= code_arr[win_idx];
          data_q <= data_arr[win_idx];
          rr_ptr <= ptr_after_win;
          state  <= SEND0;
        end

        SEND0: begin
          if (!tx_busy) begin
            tx_data  <= frame_hdr(code_q, win_idx);
            tx_start <= 1'b1;
            state    <= WAIT0;
          end
        end

        WAIT0: begin
          if (tx_done) begin
            state <= SEND1;
          end
        end

        SEND1: begin
          if (!tx_busy) begin
            tx_data  <= frame_data(data_q);
            tx_start <= 1'b1;
            state    <= WAIT1;
          end
        end

        WAIT1: begin
          if (tx_done) begin
`ifdef COLETOR_CHECKSUM_EN
            state <= SEND2;
`else
            busy  <= 1'b0;
            state <= IDLE;
`endif
          end
        end

`ifdef COLETOR_CHECKSUM_EN
        SEND2: begin
          if (!tx_busy) begin
            tx_data  <= frame_csum(code_q, win_idx, data_q);
            tx_start <= 1'b1;
            state    <= WAIT2;
          end
        end

        WAIT2: begin
          if (tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coletor_tx.sv
module tb_coletor_tx;

  localparam int N        = 32;
  localparam int UART_DLY = 10;
`ifdef COLETOR_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic             clk;
  logic             reset;
  logic [N-1:0]     req;
  logic [3*N-1:0]   resp_code_bus;
  logic [8*N-1:0]   resp_data_bus;
  logic [N-1:0]     ack;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             tx_done;
  logic             busy;

  coletor_tx #(.N_SENSORS(N), .DATA_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .resp_code_bus (resp_code_bus),
    .resp_data_bus (resp_data_bus),
    .ack           (ack),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  // bench-side state
  int          cyc = 0;
  int          uart_cnt = 0;
  int          busy_hold = 0;
  bit          spur = 0;
  bit          rand_dly = 0;
  bit          auto_drop = 1;
  int          hook_idx = -1;
  logic [N-1:0] hook_mask = '0;
  bit          model_en = 0;
  int          m_ptr = 0;
  logic        prev_busy = 1'b0;
  int          busy_rise = -1;
  int          busy_fall = -1;
  logic [2:0]  mod_code [N];
  logic [7:0]  mod_data [N];

  int          ack_q[$];
  int          ack_cyc[$];
  logic [7:0]  byte_q[$];
  int          byte_cyc[$];
  logic [7:0]  exp_q[$];

  typedef struct {
    int         idx;
    logic [2:0] code;
    logic [7:0] data;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_mod(input int i, input logic [2:0] c, input logic [7:0] d);
    mod_code[i] = c;
    mod_data[i] = d;
    resp_code_bus[3*i +: 3] = c;
    resp_data_bus[8*i +: 8] = d;
  endtask

  // Reference: round-robin over the request set seen at arbitration, frame
  // bytes built from the bench's own copy of each module's code and data.
  task automatic model_capture(input int w);
    int e;
    logic [7:0] h;
    e = -1;
    for (int k = 0; k < N; k++) begin
      if (e < 0 && req[(m_ptr + k) % N]) e = (m_ptr + k) % N;
    end
    check("rand_rr_winner", w, e);
    if (e >= 0) begin
      m_ptr = (e + 1) % N;
      h = {mod_code[e], 5'(e)};
      exp_q.push_back(h);
      exp_q.push_back(mod_data[e]);
`ifdef COLETOR_CHECKSUM_EN
      exp_q.push_back(h ^ mod_data[e]);
`endif
    end
  endtask

  // One clock: sample outputs after the falling edge, then play the sensing
  // modules and the UART transmitter for the next rising edge.
  task automatic tick();
    int w;
    @(negedge clk);
    #1;
    cyc++;
    if (busy && !prev_busy) busy_rise = cyc;
    if (!busy && prev_busy) busy_fall = cyc;
    prev_busy = busy;
    if (ack != '0) begin
      check("ack_onehot", $countones(ack), 1);
      w = idx_of(ack);
      ack_q.push_back(w);
      ack_cyc.push_back(cyc);
      if (model_en) model_capture(w);
      if (auto_drop) req = req & ~ack;
      if (w == hook_idx) begin
        req = req | hook_mask;
        hook_idx = -1;
      end
    end
    tx_done = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) tx_done = 1'b1;
    end
    if (tx_start) begin
      byte_q.push_back(tx_data);
      byte_cyc.push_back(cyc);
      uart_cnt = rand_dly ? int'($urandom_range(1, 12)) : UART_DLY;
      if (model_en) begin
        check("rand_byte_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("rand_byte", tx_data, exp_q.pop_front());
      end
    end
    if (spur) begin
      tx_done = 1'b1;
      spur = 0;
    end
    if (busy_hold > 0) begin
      busy_hold--;
      tx_busy = 1'b1;
    end else begin
      tx_busy = (uart_cnt > 0);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < budget) begin
      tick();
      n++;
      if (req == '0 && !busy && uart_cnt == 0) quiet++;
      else quiet = 0;
    end
    check({name, "_completes"}, 32'(quiet >= 3), 1);
  endtask

  task automatic clear_logs();
    ack_q.delete();
    ack_cyc.delete();
    byte_q.delete();
    byte_cyc.delete();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req = '0;
    uart_cnt = 0;
    busy_hold = 0;
    spur = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic add_rand(input int n);
    int i;
    for (int k = 0; k < n; k++) begin
      i = int'($urandom_range(0, N - 1));
      if (!req[i]) begin
        set_mod(i, 3'($urandom), 8'($urandom));
        req[i] = 1'b1;
      end
    end
  endtask

  initial begin
    int t0;
    int viol;
    int n;
    int exp_order [$];

    vecs[0] = '{5,  3'b101, 8'hA7, 8'hA5, 8'hA7, 8'h02};
    vecs[1] = '{0,  3'b000, 8'h5C, 8'h00, 8'h5C, 8'h5C};
    vecs[2] = '{31, 3'b111, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{17, 3'b010, 8'h3C, 8'h51, 8'h3C, 8'h6D};
    vecs[4] = '{8,  3'b110, 8'h81, 8'hC8, 8'h81, 8'h49};

    reset = 1'b1;
    req = '0;
    resp_code_bus = '0;
    resp_data_bus = '0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    for (int i = 0; i < N; i++) set_mod(i, 3'(i), 8'(i * 7));

    // reset state
    tick();
    tick();
    check("reset_ack", ack, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_tx_start", tx_start, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;

    // idle with no requests, spurious tx_done
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) spur = 1;
      tick();
      if (busy || tx_start || ack != '0) viol++;
    end
    check("idle_quiet", viol, 0);

    // single-request frames from the table
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      set_mod(vecs[v].idx, vecs[v].code, vecs[v].data);
      req = '0;
      req[vecs[v].idx] = 1'b1;
      t0 = cyc;
      drain(200, "vec_frame");
      check($sformatf("vec%0d_ack_count", v), ack_q.size(), 1);
      if (ack_q.size() >= 1) begin
        check($sformatf("vec%0d_ack_idx", v), ack_q[0], vecs[v].idx);
        check($sformatf("vec%0d_ack_cycle", v), ack_cyc[0] - t0, 1);
      end
      check($sformatf("vec%0d_busy_rise", v), busy_rise - t0, 1);
      check($sformatf("vec%0d_byte_count", v), byte_q.size(), NB);
      if (byte_q.size() == NB) begin
        check($sformatf("vec%0d_byte0", v), byte_q[0], vecs[v].b0);
        check($sformatf("vec%0d_byte1", v), byte_q[1], vecs[v].b1);
`ifdef COLETOR_CHECKSUM_EN
        check($sformatf("vec%0d_byte2", v), byte_q[2], vecs[v].b2);
`endif
        check($sformatf("vec%0d_start_latency", v), byte_cyc[0] - t0, 3);
        check($sformatf("vec%0d_busy_fall", v), busy_fall - byte_cyc[NB-1], UART_DLY + 1);
      end
      check($sformatf("vec%0d_busy_low", v), busy, 0);
    end

    // tx_busy gating plus spurious tx_done in CAPTURE and SEND0
    clear_logs();
    set_mod(12, 3'b001, 8'h5A);
    busy_hold = 22;
    req = '0;
    req[12] = 1'b1;
    t0 = cyc;
    spur = 1;
    tick();
    tick();
    tick();
    spur = 1;
    drain(300, "gate_frame");
    check("gate_byte_count", byte_q.size(), NB);
    if (byte_q.size() == NB) begin
      check("gate_byte0", byte_q[0], 8'h2C);
      check("gate_byte1", byte_q[1], 8'h5A);
      check("gate_first_start", byte_cyc[0] - t0, 22 + 2);
    end

    // round-robin order with re-request during the last frame
    reset_dut();
    clear_logs();
    req = '0;
    req[0] = 1'b1; req[3] = 1'b1; req[31] = 1'b1;
    hook_idx = 31;
    hook_mask = '0; hook_mask[0] = 1'b1; hook_mask[3] = 1'b1;
    drain(600, "rr_frames");
    exp_order = '{0, 3, 31, 0, 3};
    check("rr_count", ack_q.size(), exp_order.size());
    for (int k = 0; k < exp_order.size() && k < ack_q.size(); k++)
      check($sformatf("rr_order_%0d", k), ack_q[k], exp_order[k]);

    // wrap-around after serving 31
    clear_logs();
    req = '0;
    req[31] = 1'b1;
    hook_idx = 31;
    hook_mask = '0; hook_mask[30] = 1'b1; hook_mask[1] = 1'b1;
    drain(600, "wrap_frames");
    exp_order = '{31, 1, 30};
    check("wrap_count", ack_q.size(), exp_order.size());
    for (int k = 0; k < exp_order.size() && k < ack_q.size(); k++)
      check($sformatf("wrap_order_%0d", k), ack_q[k], exp_order[k]);

    // reset between byte0's tx_done and byte1's tx_start
    clear_logs();
    set_mod(7, 3'b011, 8'hC3);
    set_mod(2, 3'b100, 8'h19);
    set_mod(9, 3'b000, 8'h11);
    req = '0;
    req[7] = 1'b1;
    n = 0;
    while (tx_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("rst_byte0_done", tx_done, 1);
    req[2] = 1'b1;
    req[9] = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_tx_start", tx_start, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_tx_data", tx_data, 0);
    check("rst_async_ack", ack, 0);
    uart_cnt = 0;
    tick();
    tick();
    check("rst_no_byte1", byte_q.size(), 1);
    reset = 1'b0;
    drain(800, "rst_frames");
    check("rst_ack_count", ack_q.size(), 3);
    if (ack_q.size() == 3) begin
      check("rst_first_after", ack_q[1], 2);
      check("rst_second_after", ack_q[2], 9);
    end
    check("rst_byte_count", byte_q.size(), 1 + 2 * NB);
    if (byte_q.size() >= 2) check("rst_hdr_after", byte_q[1], 8'h82);

    // randomized traffic against the reference model
    reset_dut();
    clear_logs();
    exp_q.delete();
    m_ptr = 0;
    model_en = 1;
    rand_dly = 1;
    for (int c = 0; c < 6000; c++) begin
      tick();
      if (busy && ack == '0) begin
        if ($urandom_range(0, 7) == 0) add_rand(1);
      end else if (!busy && req == '0) begin
        add_rand(int'($urandom_range(1, 3)));
      end
    end
    drain(3000, "rand_drain");
    check("rand_all_bytes_sent", exp_q.size(), 0);
    check("rand_enough_frames", 32'(ack_q.size() > 50), 1);
    model_en = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
